// File: rtl/apb_regbank_if.sv
// apb_regbank_if: APB slave front-end for a flat bank of 32-bit registers.
// A transfer is captured in the setup phase, optionally stretched by
// WAIT_CYCLES wait states, and completed with a one-cycle apb_ack. Writes
// are forwarded to the register bank as a single-cycle reg_wen pulse.
// Optional feature macro: APB_REGBANK_SLVERR_EN drives apb_err from the
// bad-access flag during ACK; without it apb_err is held at 0.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_regbank_if #(
  parameter int                 REG_NUM     = 16,
  parameter logic [REG_NUM-1:0] RO_MASK     = {REG_NUM{1'b0}},
  parameter int                 WAIT_CYCLES = 0,
  localparam int                RA_W        = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       apb_psel,
  input  logic                       apb_enab,
  input  logic                       apb_rw,
  input  logic [`ADDR_WIDTH-1:0]     apb_addr,
  input  logic [`APB_DATA_WIDTH-1:0] apb_datai,
  input  logic [3:0]                 apb_strb,
  output logic [`APB_DATA_WIDTH-1:0] apb_datao,
  output logic                       apb_ack,
  output logic                       apb_err,
  input  logic [REG_NUM*32-1:0]      reg_rdata,
  output logic                       reg_wen,
  output logic [RA_W-1:0]            reg_addr,
  output logic [31:0]                reg_wdata,
  output logic [3:0]                 reg_wstrb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t       state_r, state_nxt_s;
  logic [3:0]   cnt_r, cnt_nxt_s;
  logic         capture_s;
  logic         enter_ack_s;

  logic [7:0]   addr_r;
  logic         rw_r;
  logic [31:0]  datai_r;
  logic [3:0]   strb_r;

  logic [7:0]   src_addr_s;
  logic         src_rw_s;
  logic [31:0]  src_data_s;
  logic [3:0]   src_strb_s;
  logic         src_bad_s;
  logic [31:0]  rd_word_s;

  logic         ack_r, err_r, wen_r;
  logic [`APB_DATA_WIDTH-1:0] datao_r;
  logic [RA_W-1:0] reg_addr_r;
  logic [31:0]  reg_wdata_r;
  logic [3:0]   reg_wstrb_r;

  // Only byte address bits [7:0] select a register; upper bits are don't-care.
  logic unused_addr_s;
  assign unused_addr_s = ^apb_addr[`ADDR_WIDTH-1:8];

  // Bad access: index beyond the bank, misaligned, or a write to a read-only register.
  function automatic logic access_bad(input logic [7:0] addr, input logic rw);
    logic hit;
    logic ro;
    hit = 1'b0;
    ro  = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      hit = hit | (addr[7:2] == 6'(i));
      ro  = ro | ((addr[7:2] == 6'(i)) & RO_MASK[i]);
    end
    return (!hit) || (addr[1:0] != 2'b00) || (rw && ro);
  endfunction

  // With zero wait states ACK is entered on the capture edge itself, so the
  // response is decoded from the live bus rather than the capture registers.
  assign src_addr_s = capture_s ? apb_addr[7:0]     : addr_r;
  assign src_rw_s   = capture_s ? apb_rw            : rw_r;
  assign src_data_s = capture_s ? apb_datai[31:0]   : datai_r;
  assign src_strb_s = capture_s ? apb_strb          : strb_r;
  assign src_bad_s  = access_bad(src_addr_s, src_rw_s);

  // Select the addressed register word for the read path
  always_comb begin
    rd_word_s = 32'd0;
    for (int i = 0; i < REG_NUM; i++) begin
      rd_word_s = rd_word_s | ((src_addr_s[7:2] == 6'(i)) ? reg_rdata[32*i +: 32] : 32'd0);
    end
  end

  // Next-state logic: setup capture, wait-state countdown with abort, one-cycle ACK
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (apb_psel && !apb_enab) begin
          capture_s   = 1'b1;
          cnt_nxt_s   = 4'(WAIT_CYCLES);
          state_nxt_s = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!apb_psel) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = ACK;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  assign enter_ack_s = (state_nxt_s == ACK);

  // FSM state, wait counter and captured transfer attributes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 8'd0;
      rw_r    <= 1'b0;
      datai_r <= 32'd0;
      strb_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        addr_r  <= apb_addr[7:0];
        rw_r    <= apb_rw;
        datai_r <= apb_datai[31:0];
        strb_r  <= apb_strb;
      end
    end
  end

  // Response and register-bank write outputs, all loaded on entry to ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      wen_r       <= 1'b0;
      datao_r     <= '0;
      reg_addr_r  <= '0;
      reg_wdata_r <= 32'd0;
      reg_wstrb_r <= 4'd0;
    end else begin
      ack_r <= enter_ack_s;
      wen_r <= enter_ack_s & src_rw_s & ~src_bad_s;
`ifdef APB_REGBANK_SLVERR_EN
      err_r <= enter_ack_s & src_bad_s;
`else
      err_r <= 1'b0;
`endif
      if (enter_ack_s && !src_rw_s) begin
        datao_r <= src_bad_s ? '0 : `APB_DATA_WIDTH'(rd_word_s);
      end
      if (enter_ack_s && src_rw_s && !src_bad_s) begin
        reg_addr_r  <= src_addr_s[RA_W+1:2];
        reg_wdata_r <= src_data_s;
        reg_wstrb_r <= src_strb_s;
      end
    end
  end

  assign apb_ack   = ack_r;
  assign apb_err   = err_r;
  assign apb_datao = datao_r;
  assign reg_wen   = wen_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign reg_wstrb = reg_wstrb_r;

endmodule

// File: doc/apb_regbank_if.md
APB_REGBANK_IF -- requirements
Module: apb_regbank_if

Interface
REQ-001 SHALL have parameter REG_NUM, default 16, number of 32-bit registers, legal range 1..64, power of two not required.
REQ-002 SHALL have parameter RO_MASK, default {REG_NUM{1'b0}}, width REG_NUM; bit i=1 makes register i read-only.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, number of wait states inserted before apb_ack, legal range 0..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port apb_psel, input, 1, slave select.
REQ-007 SHALL have port apb_enab, input, 1, APB enable phase.
REQ-008 SHALL have port apb_rw, input, 1, transfer direction: 0 read, 1 write.
REQ-009 SHALL have port apb_addr, input, `ADDR_WIDTH, byte address.
REQ-010 SHALL have port apb_datai, input, `APB_DATA_WIDTH, write data.
REQ-011 SHALL have port apb_strb, input, 4, byte write strobes.
REQ-012 SHALL have port apb_datao, output, `APB_DATA_WIDTH, read data.
REQ-013 SHALL have port apb_ack, output, 1, transfer complete (PREADY).
REQ-014 SHALL have port apb_err, output, 1, slave error, valid only while apb_ack=1.
REQ-015 SHALL have port reg_rdata, input, REG_NUM*32, flat register contents; register i occupies bits [32i+31:32i].
REQ-016 SHALL have port reg_wen, output, 1, single-cycle write pulse.
REQ-017 SHALL have port reg_addr, output, $clog2(REG_NUM) (minimum 1), register index of the write.
REQ-018 SHALL have port reg_wdata, output, 32, write data.
REQ-019 SHALL have port reg_wstrb, output, 4, byte enables of the write.

Function
REQ-020 SHALL compute index = apb_addr[7:2]; an access is bad if index>=REG_NUM or apb_addr[1:0]!=0, and a write is also bad if RO_MASK[index]=1.
REQ-021 SHALL implement a three-state FSM: IDLE, WAIT, ACK.
REQ-022 IDLE: on apb_psel=1 and apb_enab=0, SHALL capture addr, rw, datai and strb, load cnt=WAIT_CYCLES, and go to ACK if WAIT_CYCLES=0, otherwise to WAIT.
REQ-023 WAIT: SHALL decrement cnt each cycle and go to ACK when cnt reaches 1; if apb_psel=0, SHALL abort to IDLE with no write.
REQ-024 ACK: SHALL assert apb_ack=1 for exactly one cycle, then return to IDLE.
REQ-025 Latency: apb_ack SHALL be high in the (WAIT_CYCLES+1)th cycle after the setup cycle, i.e. the first enable cycle when WAIT_CYCLES=0.
REQ-026 Read: apb_datao SHALL be registered on entry to ACK from reg_rdata at the captured index, equal 0 for a bad access, and hold its value until the next read.
REQ-027 Good write: reg_wen=1, reg_addr, reg_wdata and reg_wstrb SHALL be valid in the ACK cycle only; reg_wen SHALL be 0 in every other cycle.
REQ-028 Bad write: reg_wen SHALL stay 0.
REQ-029 A write with apb_strb=0 SHALL still pulse reg_wen, with reg_wstrb=0.
REQ-030 apb_ack SHALL be 0 outside the ACK state; a new setup phase arriving during WAIT or ACK SHALL be ignored.

Reset
REQ-031 While reset=1 at a clock edge, the FSM SHALL go to IDLE, including from mid-transfer, and the aborted write SHALL NOT occur.
REQ-032 Reset values SHALL be: apb_ack=0, apb_err=0, apb_datao=0, reg_wen=0, reg_addr=0, reg_wdata=0, reg_wstrb=0, cnt=0.

Configuration
REQ-033 With macro APB_REGBANK_SLVERR_EN defined, apb_err SHALL equal the bad flag (REQ-020) during ACK and be 0 otherwise.
REQ-034 Without APB_REGBANK_SLVERR_EN, apb_err SHALL be tied to 0; bad reads still return 0 and bad writes are still dropped.

Verification
REQ-035 Scenario: WAIT_CYCLES=0, write 0xDEADBEEF to addr 0x08 with strb=0xF -> ack in first enable cycle; reg_wen pulses once with reg_addr=2, reg_wdata=0xDEADBEEF.
REQ-036 Scenario: WAIT_CYCLES=3, read addr 0x0C with reg_rdata word3=0x12345678 -> ack in 4th cycle after setup; apb_datao=0x12345678; apb_err=0.
REQ-037 Scenario: REG_NUM=16, SLVERR_EN defined, read addr 0x40 and write to a RO_MASK register -> apb_err=1 with ack; apb_datao=0; no reg_wen; same run without the macro -> apb_err=0.
REQ-038 Scenario: write to addr 0x06 (misaligned) -> no reg_wen; apb_err=1 if the macro is defined.
REQ-039 Scenario: WAIT_CYCLES=5, reset asserted 2 cycles into WAIT -> state IDLE, ack never asserted, reg_wen never asserted; the next transfer completes normally.
REQ-040 Scenario: WAIT_CYCLES=4, apb_psel dropped during WAIT -> abort, no ack, no write; back-to-back transfers each complete with exactly one ack.
